// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver: frame geometry,
// scancode set 2 values with special meaning, control ASCII codes and the
// glyph record produced by the scancode lookup table.
package ps2_pkg;

    // Device-to-host frame: start, 8 data bits, odd parity, stop
    localparam int FRAME_BITS = 11;

    // Scancode set 2 values handled by the modifier/prefix logic
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    // Control characters emitted by the decoder
    localparam logic [7:0] ASC_NUL   = 8'h00;
    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_TAB   = 8'h09;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_ESC   = 8'h1B;
    localparam logic [7:0] ASC_SPACE = 8'h20;

    // One lookup-table entry: unshifted and shifted glyph plus key class
    typedef struct packed {
        logic [7:0] lower;
        logic [7:0] upper;
        logic       letter;
        logic       mapped;
    } glyph_t;

    // Letter entry: the shifted glyph is the upper-case form of the lower one
    function automatic glyph_t mk_letter(input logic [7:0] lc);
        glyph_t g;
        g.lower  = lc;
        g.upper  = lc - 8'h20;
        g.letter = 1'b1;
        g.mapped = 1'b1;
        return g;
    endfunction

    // Non-letter entry with explicit unshifted/shifted glyphs
    function automatic glyph_t mk_sym(input logic [7:0] lo, input logic [7:0] hi);
        glyph_t g;
        g.lower  = lo;
        g.upper  = hi;
        g.letter = 1'b0;
        g.mapped = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/ps2_scancode_to_ascii.sv
// Combinational scancode set 2 to ASCII table. Letters follow shift XOR caps,
// every other mapped key follows shift alone. Codes not in the table report
// mapped=0 and ascii=0.
module ps2_scancode_to_ascii
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii,
    output logic       mapped
);

    glyph_t g;

    // Table lookup followed by glyph selection from the modifier state
    always_comb begin
        g = '0;
        case (code)
            // letters
            8'h1C: g = mk_letter(8'h61);
            8'h32: g = mk_letter(8'h62);
            8'h21: g = mk_letter(8'h63);
            8'h23: g = mk_letter(8'h64);
            8'h24: g = mk_letter(8'h65);
            8'h2B: g = mk_letter(8'h66);
            8'h34: g = mk_letter(8'h67);
            8'h33: g = mk_letter(8'h68);
            8'h43: g = mk_letter(8'h69);
            8'h3B: g = mk_letter(8'h6A);
            8'h42: g = mk_letter(8'h6B);
            8'h4B: g = mk_letter(8'h6C);
            8'h3A: g = mk_letter(8'h6D);
            8'h31: g = mk_letter(8'h6E);
            8'h44: g = mk_letter(8'h6F);
            8'h4D: g = mk_letter(8'h70);
            8'h15: g = mk_letter(8'h71);
            8'h2D: g = mk_letter(8'h72);
            8'h1B: g = mk_letter(8'h73);
            8'h2C: g = mk_letter(8'h74);
            8'h3C: g = mk_letter(8'h75);
            8'h2A: g = mk_letter(8'h76);
            8'h1D: g = mk_letter(8'h77);
            8'h22: g = mk_letter(8'h78);
            8'h35: g = mk_letter(8'h79);
            8'h1A: g = mk_letter(8'h7A);
            // digit row
            8'h45: g = mk_sym(8'h30, 8'h29);
            8'h16: g = mk_sym(8'h31, 8'h21);
            8'h1E: g = mk_sym(8'h32, 8'h40);
            8'h26: g = mk_sym(8'h33, 8'h23);
            8'h25: g = mk_sym(8'h34, 8'h24);
            8'h2E: g = mk_sym(8'h35, 8'h25);
            8'h36: g = mk_sym(8'h36, 8'h5E);
            8'h3D: g = mk_sym(8'h37, 8'h26);
            8'h3E: g = mk_sym(8'h38, 8'h2A);
            8'h46: g = mk_sym(8'h39, 8'h28);
            // punctuation
            8'h0E: g = mk_sym(8'h60, 8'h7E);
            8'h4E: g = mk_sym(8'h2D, 8'h5F);
            8'h55: g = mk_sym(8'h3D, 8'h2B);
            8'h54: g = mk_sym(8'h5B, 8'h7B);
            8'h5B: g = mk_sym(8'h5D, 8'h7D);
            8'h5D: g = mk_sym(8'h5C, 8'h7C);
            8'h4C: g = mk_sym(8'h3B, 8'h3A);
            8'h52: g = mk_sym(8'h27, 8'h22);
            8'h41: g = mk_sym(8'h2C, 8'h3C);
            8'h49: g = mk_sym(8'h2E, 8'h3E);
            8'h4A: g = mk_sym(8'h2F, 8'h3F);
            // control keys, identical shifted or not
            8'h29: g = mk_sym(ASC_SPACE, ASC_SPACE);
            8'h5A: g = mk_sym(ASC_CR, ASC_CR);
            8'h66: g = mk_sym(ASC_BS, ASC_BS);
            8'h0D: g = mk_sym(ASC_TAB, ASC_TAB);
            8'h76: g = mk_sym(ASC_ESC, ASC_ESC);
            default: g = '0;
        endcase

        mapped = g.mapped;
        if (g.letter) begin
            ascii = (shift ^ caps) ? g.upper : g.lower;
        end else begin
            ascii = shift ? g.upper : g.lower;
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver. Synchronises the raw keyboard lines, deframes
// 11-bit device-to-host frames on falling PS/2 clock edges, abandons partial
// frames after a quiet period, and turns set 2 scancodes into ASCII strobes
// while tracking shift, caps-lock and the E0/F0 prefixes.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii,
    output logic       new_char,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT     = 4'(FRAME_BITS - 1);

    // Synchroniser chains; clk_prev_q is the synchronised clock one cycle late
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic data_s1_q, data_s2_q;
    logic fall;

    // Deframer state
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic          code_valid_q, code_valid_d;
    logic          code_ok_q, code_ok_d;
    logic [7:0]    code_q, code_d;

    // Modifier / prefix state and output registers
    logic       lshift_q, lshift_d;
    logic       rshift_q, rshift_d;
    logic       caps_q, caps_d;
    logic       break_q, break_d;
    logic       ext_q, ext_d;
    logic [7:0] ascii_q, ascii_d;
    logic       new_char_q, new_char_d;
    logic       frame_err_q, frame_err_d;

    logic [7:0] lut_ascii;
    logic       lut_mapped;

    assign fall = clk_prev_q & ~clk_s2_q;

    ps2_scancode_to_ascii u_lut (
        .code   (code_q),
        .shift  (lshift_q | rshift_q),
        .caps   (caps_q),
        .ascii  (lut_ascii),
        .mapped (lut_mapped)
    );

    // Deframer: collect bits on falling edges, judge the frame on bit 10,
    // and drop a partial frame when the keyboard goes quiet
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        timeout_d    = timeout_q;
        code_valid_d = 1'b0;
        code_ok_d    = code_ok_q;
        code_d       = code_q;
        if (fall) begin
            timeout_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
                // Stop bit arrives live from the synchroniser; the rest is stored
                bit_cnt_d    = '0;
                code_valid_d = 1'b1;
                code_d       = shift_q[8:1];
                code_ok_d    = ~shift_q[0] & data_s2_q & (^shift_q[9:1]);
            end else begin
                shift_d[bit_cnt_q] = data_s2_q;
                bit_cnt_d          = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (timeout_q == TIMEOUT_LAST) begin
                bit_cnt_d = '0;
                timeout_d = '0;
            end else begin
                timeout_d = timeout_q + TW'(1);
            end
        end else begin
            timeout_d = '0;
        end
    end

    // Decoder: prefix/modifier tracking and next values of the output registers
    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_d      = caps_q;
        break_d     = break_q;
        ext_d       = ext_q;
        ascii_d     = ascii_q;
        new_char_d  = 1'b0;
        frame_err_d = 1'b0;
        if (code_valid_q) begin
            if (!code_ok_q) begin
                // Corrupt frame: report it and leave every prefix untouched
                frame_err_d = 1'b1;
            end else if (code_q == SC_EXT) begin
                ext_d = 1'b1;
            end else if (code_q == SC_BREAK) begin
                break_d = 1'b1;
            end else if (break_q) begin
                // Key release only matters for the shift keys
                if (code_q == SC_LSHIFT) lshift_d = 1'b0;
                if (code_q == SC_RSHIFT) rshift_d = 1'b0;
                break_d = 1'b0;
                ext_d   = 1'b0;
            end else if (ext_q) begin
                // Of the extended keys only keypad enter produces a character
                if (code_q == SC_ENTER) begin
                    ascii_d    = ASC_CR;
                    new_char_d = 1'b1;
                end
                ext_d = 1'b0;
            end else if (code_q == SC_LSHIFT) begin
                lshift_d = 1'b1;
            end else if (code_q == SC_RSHIFT) begin
                rshift_d = 1'b1;
            end else if (code_q == SC_CAPS) begin
                caps_d = ~caps_q;
            end else if (lut_mapped) begin
                ascii_d    = lut_ascii;
                new_char_d = 1'b1;
            end
        end
    end

    // State update; synchronisers reset to the idle-high line level so that
    // leaving reset can never look like a falling edge
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            clk_prev_q   <= 1'b1;
            data_s1_q    <= 1'b1;
            data_s2_q    <= 1'b1;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            timeout_q    <= '0;
            code_valid_q <= 1'b0;
            code_ok_q    <= 1'b0;
            code_q       <= '0;
            lshift_q     <= 1'b0;
            rshift_q     <= 1'b0;
            caps_q       <= 1'b0;
            break_q      <= 1'b0;
            ext_q        <= 1'b0;
            ascii_q      <= ASC_NUL;
            new_char_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_s1_q     <= ps2_clk;
            clk_s2_q     <= clk_s1_q;
            clk_prev_q   <= clk_s2_q;
            data_s1_q    <= ps2_data;
            data_s2_q    <= data_s1_q;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            timeout_q    <= timeout_d;
            code_valid_q <= code_valid_d;
            code_ok_q    <= code_ok_d;
            code_q       <= code_d;
            lshift_q     <= lshift_d;
            rshift_q     <= rshift_d;
            caps_q       <= caps_d;
            break_q      <= break_d;
            ext_q        <= ext_d;
            ascii_q      <= ascii_d;
            new_char_q   <= new_char_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign ascii     = ascii_q;
    assign new_char  = new_char_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: PS/2 frames are bit-banged onto the raw lines,
// expected strobes are queued before each frame and checked by a monitor
// as the DUT produces them.
module tb_ps2_keyboard_rx;

    localparam int HALF = 20;   // PS/2 half period in system clocks

    typedef struct {
        bit         is_err;
        logic [7:0] ascii;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] ascii;
    logic       new_char;
    logic       frame_err;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] exp_ascii = 8'h00;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         edge_cyc = 0;
    int         strobe_cyc = 0;

    ps2_keyboard_rx #(.TIMEOUT_CYCLES(5000)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ascii     (ascii),
        .new_char  (new_char),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && (new_char || frame_err)) begin
            total++;
            strobe_cyc = cyc;
            if (new_char && frame_err) begin
                bad++;
                $display("FAIL both_strobes: new_char=%b frame_err=%b, required one at a time", new_char, frame_err);
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: new_char=%b frame_err=%b ascii=%h, required none", new_char, frame_err, ascii);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_err) begin
                    if (frame_err !== 1'b1) begin
                        bad++;
                        $display("FAIL strobe_kind: got new_char ascii=%h, required frame_err", ascii);
                    end
                end else if (new_char !== 1'b1 || ascii !== mon_e.ascii) begin
                    bad++;
                    $display("FAIL char: new_char=%b ascii=%h, required new_char=1 ascii=%h", new_char, ascii, mon_e.ascii);
                end else begin
                    $display("char ok: ascii=%h", ascii);
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) edge_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        $display("sent frame %h bad_par=%0d bad_stop=%0d bits=%0d", code, bad_par, bad_stop, nbits);
    endtask

    task automatic send(input logic [7:0] code);
        send_frame(code, 1'b0, 1'b0, 11);
    endtask

    task automatic expect_char(input logic [7:0] c);
        exp_t e;
        e.is_err = 1'b0;
        e.ascii  = c;
        sb.push_back(e);
        exp_ascii = c;
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.ascii  = 8'h00;
        sb.push_back(e);
    endtask

    // Let outstanding strobes land, then require an empty scoreboard and held ascii
    task automatic drain(input string name);
        repeat (60) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_missing: %0d strobes outstanding, required 0", name, sb.size());
            sb.delete();
        end
        total++;
        if (ascii !== exp_ascii) begin
            bad++;
            $display("FAIL %s_ascii_held: ascii=%h, required %h", name, ascii, exp_ascii);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (ascii !== 8'h00) begin bad++; $display("FAIL reset_ascii: %h, required 00", ascii); end
        total++;
        if (new_char !== 1'b0) begin bad++; $display("FAIL reset_new_char: %b, required 0", new_char); end
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: %b, required 0", frame_err); end
        $display("reset checked");
    endtask

    task automatic test_basic();
        expect_char(8'h61);
        send(8'h1C);
        total++;
        if (strobe_cyc - edge_cyc !== 4) begin
            bad++;
            $display("FAIL latency: %0d cycles from raw edge, required 4", strobe_cyc - edge_cyc);
        end
        drain("basic");
        send(8'hF0);
        send(8'h1C);
        drain("basic_release");
    endtask

    task automatic test_shift();
        send(8'h12);
        expect_char(8'h41);
        send(8'h1C);
        send(8'hF0);
        send(8'h12);
        expect_char(8'h61);
        send(8'h1C);
        send(8'h59);
        expect_char(8'h3F);
        send(8'h4A);
        send(8'hF0);
        send(8'h59);
        expect_char(8'h2F);
        send(8'h4A);
        drain("shift");
    endtask

    task automatic test_caps();
        send(8'h58);
        expect_char(8'h41);
        send(8'h1C);
        expect_char(8'h31);
        send(8'h16);
        send(8'h12);
        expect_char(8'h61);
        send(8'h1C);
        expect_char(8'h21);
        send(8'h16);
        send(8'hF0);
        send(8'h12);
        send(8'h58);
        expect_char(8'h7A);
        send(8'h1A);
        drain("caps");
    endtask

    task automatic test_errors();
        expect_err();
        send_frame(8'h1C, 1'b1, 1'b0, 11);
        expect_err();
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        drain("errors");
        // A corrupt frame must not consume a pending prefix
        send(8'hE0);
        expect_err();
        send_frame(8'h5A, 1'b1, 1'b0, 11);
        send(8'h1C);
        send(8'hF0);
        expect_err();
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        send(8'h1C);
        expect_char(8'h61);
        send(8'h1C);
        drain("errors_prefix");
    endtask

    task automatic test_timeout();
        send_frame(8'h1C, 1'b0, 1'b0, 4);
        repeat (6000) @(negedge clk);
        expect_char(8'h0D);
        send(8'h5A);
        drain("timeout");
    endtask

    task automatic test_ext();
        expect_char(8'h0D);
        send(8'hE0);
        send(8'h5A);
        send(8'hE0);
        send(8'h75);
        send(8'h7E);
        send(8'hE0);
        send(8'hF0);
        send(8'h5A);
        drain("ext");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            expect_char(8'h61);
            send(8'h1C);
        end
        expect_char(8'h2D);
        send(8'h4E);
        send(8'h12);
        expect_char(8'h5F);
        send(8'h4E);
        send(8'hF0);
        send(8'h12);
        expect_char(8'h20);
        send(8'h29);
        drain("back_to_back");
    endtask

    task automatic test_reset_midframe();
        send(8'h58);
        send_frame(8'h29, 1'b0, 1'b0, 6);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_ascii = 8'h00;
        expect_char(8'h20);
        send(8'h29);
        expect_char(8'h61);
        send(8'h1C);
        drain("reset_midframe");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_caps();
        test_errors();
        test_timeout();
        test_ext();
        test_back_to_back();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
